pagerank_sync_ctrl: RTL and testbench

PAGERANK_SYNC_CTRL -- requirements
Module: pagerank_sync_ctrl

---
 rtl/pagerank_sync_ctrl_if.sv | 38 +++
 rtl/pagerank_sync_ctrl.sv | 135 +++++++++++++
 tb/tb_pagerank_sync_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/pagerank_sync_ctrl_if.sv
// Purpose: bundles the host, ant-barrier and sorter signals of the PageRank iteration controller.
// Latency: none (wires only).
// Backpressure: none. Ants hold syc_out high until they receive syc_in.
// Ports: master = environment (host, ants, sorter); slave = pagerank_sync_ctrl.
interface pagerank_sync_ctrl_if #(
   parameter int P     = 4,
   parameter int WIDTH = 16,
   parameter int IW    = 9
);
   // host -> controller
   logic               start;
   logic [P-1:0]       ant_mask;
   logic               conv_en;
   logic [WIDTH-1:0]   eps;
   // ants -> controller
   logic [P-1:0]       syc_out;
   logic [P*WIDTH-1:0] delta;
   // sorter -> controller
   logic               sort_done;
   // controller -> environment
   logic               syc_in;
   logic               sort_start;
   logic [IW-1:0]      iter_count;
   logic [WIDTH-1:0]   max_delta;
   logic               busy;
   logic               done;
   logic               converged;

   modport master (
      output start, ant_mask, conv_en, eps, syc_out, delta, sort_done,
      input  syc_in, sort_start, iter_count, max_delta, busy, done, converged
   );

   modport slave (
      input  start, ant_mask, conv_en, eps, syc_out, delta, sort_done,
      output syc_in, sort_start, iter_count, max_delta, busy, done, converged
   );
endinterface

// File: rtl/pagerank_sync_ctrl.sv
// Purpose: barrier-synchronises P ant partitions per PageRank iteration, then stops on an
//          iteration limit or on convergence and launches the top-10 sorter.
// Latency: barrier edge -> syc_in or sort_start in the next cycle. All outputs are registered.
// Backpressure: ants hold syc_out until syc_in. start is ignored while busy.
//               sort_done is ignored except in SORT after the sort_start cycle.
// Ports: clk, reset (async, active-low) and bus (pagerank_sync_ctrl_if.slave).
module pagerank_sync_ctrl #(
   parameter int P        = 4,
   parameter int WIDTH    = 16,
   parameter int MAX_ITER = 400,
   parameter int MIN_ITER = 2,
   parameter int IW       = 9
) (
   input  logic                 clk,
   input  logic                 reset,
   pagerank_sync_ctrl_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LAUNCH = 3'd1,
      S_RUN    = 3'd2,
      S_SORT   = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t           state;
   logic [P-1:0]     mask_q;
   logic             conv_en_q;
   logic [WIDTH-1:0] eps_q;

   logic             syc_in_q;
   logic             sort_start_q;
   logic [IW-1:0]    iter_q;
   logic [WIDTH-1:0] max_q;
   logic             busy_q;
   logic             done_q;
   logic             conv_q;

   logic [WIDTH-1:0] iter_max;
   logic [IW-1:0]    next_count;
   logic             barrier;
   logic             hit_limit;
   logic             hit_conv;

   // Largest delta among participating ants. Unmasked slices are ignored.
   always_comb begin
      iter_max = '0;
      for (int i = 0; i < P; i++) begin
         if (mask_q[i] && (bus.delta[i*WIDTH +: WIDTH] > iter_max)) begin
            iter_max = bus.delta[i*WIDTH +: WIDTH];
         end
      end
   end

   // In the release cycle, syc_out is still high from the iteration just counted.
   // That cycle must not be taken as a new barrier.
   assign barrier    = ((bus.syc_out & mask_q) == mask_q) && !syc_in_q;
   assign next_count = iter_q + 1'b1;
   assign hit_limit  = (next_count == IW'(MAX_ITER));
   assign hit_conv   = conv_en_q && (next_count >= IW'(MIN_ITER)) && (iter_max <= eps_q);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= S_IDLE;
         mask_q       <= '0;
         conv_en_q    <= 1'b0;
         eps_q        <= '0;
         syc_in_q     <= 1'b0;
         sort_start_q <= 1'b0;
         iter_q       <= '0;
         max_q        <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         conv_q       <= 1'b0;
      end else begin
         // The release and sorter launch outputs are single-cycle pulses.
         syc_in_q     <= 1'b0;
         sort_start_q <= 1'b0;
         case (state)
            S_IDLE, S_DONE: begin
               if (bus.start && (bus.ant_mask != '0)) begin
                  state     <= S_LAUNCH;
                  mask_q    <= bus.ant_mask;
                  conv_en_q <= bus.conv_en;
                  eps_q     <= bus.eps;
                  iter_q    <= '0;
                  max_q     <= '0;
                  conv_q    <= 1'b0;
                  done_q    <= 1'b0;
                  busy_q    <= 1'b1;
                  syc_in_q  <= 1'b1;   // high for the LAUNCH cycle
               end
            end
            S_LAUNCH: begin
               state <= S_RUN;
            end
            S_RUN: begin
               if (barrier) begin
                  iter_q <= next_count;
                  max_q  <= iter_max;
                  if (hit_limit || hit_conv) begin
                     state        <= S_SORT;
                     sort_start_q <= 1'b1;
                     // If both causes apply, convergence is reported.
                     conv_q       <= hit_conv;
                  end else begin
                     syc_in_q <= 1'b1;
                  end
               end
            end
            S_SORT: begin
               // sort_done is not accepted in the sort_start cycle itself.
               if (bus.sort_done && !sort_start_q) begin
                  state  <= S_DONE;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.syc_in     = syc_in_q;
   assign bus.sort_start = sort_start_q;
   assign bus.iter_count = iter_q;
   assign bus.max_delta  = max_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.converged  = conv_q;

endmodule

// File: tb/tb_pagerank_sync_ctrl.sv
// Purpose: directed self-checking bench for pagerank_sync_ctrl (P=4, WIDTH=16, MAX_ITER=8, MIN_ITER=2).
// Latency: checks the 1-cycle barrier -> syc_in / sort_start timing.
// Backpressure: ants are modelled holding syc_out until syc_in or sort_start is seen.
module tb_pagerank_sync_ctrl;
   localparam int P  = 4;
   localparam int W  = 16;
   localparam int MI = 8;
   localparam int IW = 4;

   logic clk;
   logic reset;
   int   vectors     = 0;
   int   miscompares = 0;
   int   n_syc       = 0;
   int   n_sort      = 0;
   int   base_syc;
   int   base_sort;

   pagerank_sync_ctrl_if #(.P(P), .WIDTH(W), .IW(IW)) bus ();

   pagerank_sync_ctrl #(.P(P), .WIDTH(W), .MAX_ITER(MI), .MIN_ITER(2), .IW(IW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.syc_in)     n_syc  <= n_syc + 1;
      if (bus.sort_start) n_sort <= n_sort + 1;
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [P*W-1:0] pk(input int a, input int b, input int c, input int d);
      logic [W-1:0] s0, s1, s2, s3;
      s0 = W'(a); s1 = W'(b); s2 = W'(c); s3 = W'(d);
      return {s3, s2, s1, s0};
   endfunction

   task automatic chk_idle_outputs(input string tag);
      chk({tag, ".syc_in"}, 32'(bus.syc_in), 0);
      chk({tag, ".sort_start"}, 32'(bus.sort_start), 0);
      chk({tag, ".iter_count"}, 32'(bus.iter_count), 0);
      chk({tag, ".max_delta"}, 32'(bus.max_delta), 0);
      chk({tag, ".busy"}, 32'(bus.busy), 0);
      chk({tag, ".done"}, 32'(bus.done), 0);
      chk({tag, ".converged"}, 32'(bus.converged), 0);
   endtask

   task automatic do_start(input string tag, input logic [P-1:0] m, input logic ce, input logic [W-1:0] e);
      bus.start = 1'b1; bus.ant_mask = m; bus.conv_en = ce; bus.eps = e;
      cyc(1);
      bus.start = 1'b0;
      chk({tag, ".launch_syc_in"}, 32'(bus.syc_in), 1);
      chk({tag, ".launch_busy"}, 32'(bus.busy), 1);
      chk({tag, ".launch_iter"}, 32'(bus.iter_count), 0);
      chk({tag, ".launch_done"}, 32'(bus.done), 0);
      chk({tag, ".launch_conv"}, 32'(bus.converged), 0);
   endtask

   // One ant iteration: answer after lat cycles, then expect a release or sorter launch in the next cycle.
   task automatic iterate(input string tag, input logic [P-1:0] raise, input logic [P*W-1:0] d,
                          input int lat, input bit exp_end, input int exp_max, input int exp_cnt);
      bit seen;
      int waited;
      seen   = 1'b0;
      waited = 0;
      cyc(lat);
      bus.syc_out = raise;
      bus.delta   = d;
      cyc(1);
      waited = 1;
      seen = bus.syc_in || bus.sort_start;
      while (!seen && waited < 20) begin
         cyc(1);
         waited++;
         seen = bus.syc_in || bus.sort_start;
      end
      chk({tag, ".latency"}, 32'(waited), 1);
      chk({tag, ".sort_start"}, 32'(bus.sort_start), 32'(exp_end));
      chk({tag, ".syc_in"}, 32'(bus.syc_in), 32'(!exp_end));
      chk({tag, ".max_delta"}, 32'(bus.max_delta), 32'(exp_max));
      chk({tag, ".iter_count"}, 32'(bus.iter_count), 32'(exp_cnt));
      bus.syc_out = '0;
   endtask

   // Called in the sort_start cycle. The early sort_done must be ignored.
   task automatic finish_sort(input string tag);
      bus.sort_done = 1'b1;
      cyc(1);
      chk({tag, ".early_done"}, 32'(bus.done), 0);
      chk({tag, ".sort_start_once"}, 32'(bus.sort_start), 0);
      chk({tag, ".sort_busy"}, 32'(bus.busy), 1);
      cyc(1);
      bus.sort_done = 1'b0;
      chk({tag, ".done"}, 32'(bus.done), 1);
      chk({tag, ".busy_off"}, 32'(bus.busy), 0);
   endtask

   initial begin
      reset = 1'b0;
      bus.start = 1'b0; bus.ant_mask = '0; bus.conv_en = 1'b0; bus.eps = '0;
      bus.syc_out = '0; bus.delta = '0; bus.sort_done = 1'b0;
      cyc(2);
      chk_idle_outputs("reset");
      reset = 1'b1;
      cyc(2);
      chk_idle_outputs("post_reset");

      // Start with an empty mask is ignored.
      bus.start = 1'b1; bus.ant_mask = '0;
      cyc(1);
      bus.start = 1'b0;
      cyc(1);
      chk("mask0.busy", 32'(bus.busy), 0);
      chk("mask0.syc_in", 32'(bus.syc_in), 0);

      // Limit run. Zero deltas and eps=FFFF would converge if conv_en were honoured.
      base_syc = n_syc; base_sort = n_sort;
      do_start("lim", 4'hF, 1'b0, 16'hFFFF);
      for (int it = 1; it <= MI; it++) begin
         iterate($sformatf("lim.it%0d", it), 4'hF, '0, 5, (it == MI), 0, it);
      end
      finish_sort("lim");
      chk("lim.syc_pulses", 32'(n_syc - base_syc), MI);
      chk("lim.sort_pulses", 32'(n_sort - base_sort), 1);
      chk("lim.iter_count", 32'(bus.iter_count), MI);
      chk("lim.converged", 32'(bus.converged), 0);

      // Convergence run restarted from DONE: maxima 3, 9, 5 with eps=5.
      do_start("conv", 4'hF, 1'b1, 16'd5);
      iterate("conv.it1", 4'hF, pk(3, 2, 1, 0), 3, 1'b0, 3, 1);
      iterate("conv.it2", 4'hF, pk(9, 4, 5, 1), 2, 1'b0, 9, 2);
      iterate("conv.it3", 4'hF, pk(5, 0, 2, 1), 4, 1'b1, 5, 3);
      finish_sort("conv");
      chk("conv.converged", 32'(bus.converged), 1);
      chk("conv.iter_count", 32'(bus.iter_count), 3);

      // MIN_ITER blocks termination at iter 1. During SORT, start is ignored.
      do_start("min", 4'hF, 1'b1, 16'd5);
      iterate("min.it1", 4'hF, pk(0, 0, 0, 0), 1, 1'b0, 0, 1);
      iterate("min.it2", 4'hF, pk(4, 1, 2, 3), 1, 1'b1, 4, 2);
      bus.start = 1'b1; bus.ant_mask = 4'hF;
      cyc(1);
      bus.start = 1'b0;
      chk("min.start_in_sort_busy", 32'(bus.busy), 1);
      chk("min.start_in_sort_syc", 32'(bus.syc_in), 0);
      chk("min.start_in_sort_iter", 32'(bus.iter_count), 2);
      bus.sort_done = 1'b1;
      cyc(1);
      bus.sort_done = 1'b0;
      chk("min.done", 32'(bus.done), 1);
      chk("min.converged", 32'(bus.converged), 1);

      // Partial mask: unmasked ants alone make no progress. sort_done in RUN is ignored.
      base_syc = n_syc;
      do_start("msk", 4'b0101, 1'b1, 16'hFFFF);
      bus.syc_out = 4'b1010; bus.delta = pk(1, 1, 1, 1); bus.sort_done = 1'b1;
      cyc(1);
      bus.sort_done = 1'b0;
      cyc(10);
      chk("msk.no_progress_iter", 32'(bus.iter_count), 0);
      chk("msk.no_progress_pulses", 32'(n_syc - base_syc), 1);
      chk("msk.run_busy", 32'(bus.busy), 1);
      chk("msk.run_done", 32'(bus.done), 0);
      bus.syc_out = '0;
      iterate("msk.it1", 4'b0101, pk(3, 15, 7, 20), 1, 1'b0, 7, 1);
      iterate("msk.it2", 4'b0101, pk(2, 99, 6, 99), 1, 1'b1, 6, 2);
      finish_sort("msk");

      // Reset during RUN at iteration 7.
      do_start("rst", 4'hF, 1'b0, 16'd0);
      for (int it = 1; it <= 7; it++) begin
         iterate($sformatf("rst.it%0d", it), 4'hF, pk(it, 0, 0, 0), 1, 1'b0, it, it);
      end
      bus.syc_out = 4'b0011;
      #2;
      reset = 1'b0;
      #1;
      chk_idle_outputs("rst.async");
      bus.syc_out = '0;
      cyc(2);
      chk_idle_outputs("rst.held");
      reset = 1'b1;
      base_syc = n_syc;
      cyc(5);
      chk("rst.no_release_before_start", 32'(n_syc - base_syc), 0);
      do_start("rst.new", 4'hF, 1'b0, 16'd0);
      iterate("rst.new.it1", 4'hF, pk(2, 8, 1, 0), 2, 1'b0, 8, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Safety net against a stuck run.
   initial begin
      #200000;
      $display("FAIL global_timeout: observed run still active, expected completion");
      $fatal(1, "timeout");
   end
endmodule
